// File: rtl/ascon_pack.sv
// Shared ASCON definitions: the five-word 320-bit state type and the
// constants used across the permutation datapath.
package ascon_pack;

  localparam int STATE_WORDS = 5;
  localparam int WORD_W      = 64;

  // Word 0 is x0, word 4 is x4.
  typedef logic [STATE_WORDS-1:0][WORD_W-1:0] type_state;

  localparam logic [WORD_W-1:0] ASCON128_IV = 64'h80400c0600000000;

endpackage

// File: rtl/ascon_state_mux.sv
// Chooses the state entering the permutation round: freshly loaded state on
// the first round, the permutation's own output on later rounds.
module ascon_state_mux
  import ascon_pack::*;
#(
  parameter bit REG_OUT = 1'b0
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  type_state permutation_i,
  input  type_state permutation_o,
  input  logic      selection_i,
  output type_state mux_o
);

  type_state sel_state;

  // Word-wise select; all five words switch together.
  for (genvar k = 0; k < STATE_WORDS; k++) begin : g_word
    assign sel_state[k] = selection_i ? permutation_o[k] : permutation_i[k];
  end

  if (REG_OUT) begin : g_reg
    always_ff @(posedge clock_i or negedge resetb_i) begin
      if (!resetb_i) mux_o <= '0;
      else           mux_o <= sel_state;
    end
  end else begin : g_comb
    // Clock and reset have no role in the combinational variant.
    logic unused_clk_rst;
    assign unused_clk_rst = clock_i ^ resetb_i;
    assign mux_o          = sel_state;
  end

endmodule

// File: tb/tb_ascon_state_mux.sv
// Bench for both the combinational and the registered variant of the state
// mux, driven side by side from the same inputs.
module tb_ascon_state_mux;
  import ascon_pack::*;

  typedef struct {
    string     name;
    bit        use_reg;
    type_state exp;
  } chk_t;

  logic      clk = 1'b0;
  logic      resetb = 1'b1;
  logic      sel = 1'b0;
  type_state pi_s, po_s;
  type_state mux_comb, mux_reg;

  chk_t q[$];
  int   errors = 0;
  int   checks = 0;
  bit   done = 1'b0;

  always #5 clk = ~clk;

  ascon_state_mux #(.REG_OUT(1'b0)) u_comb (
    .clock_i(clk), .resetb_i(resetb), .permutation_i(pi_s),
    .permutation_o(po_s), .selection_i(sel), .mux_o(mux_comb)
  );

  ascon_state_mux #(.REG_OUT(1'b1)) u_reg (
    .clock_i(clk), .resetb_i(resetb), .permutation_i(pi_s),
    .permutation_o(po_s), .selection_i(sel), .mux_o(mux_reg)
  );

  // Reference: every word comes from the side named by the selector.
  function automatic type_state model(input logic s, input type_state a, input type_state b);
    type_state r;
    for (int k = 0; k < STATE_WORDS; k++) r[k] = s ? b[k] : a[k];
    return r;
  endfunction

  function automatic type_state rand_state();
    type_state r;
    for (int k = 0; k < STATE_WORDS; k++) r[k] = {$urandom, $urandom};
    return r;
  endfunction

  task automatic expect_out(input string name, input bit use_reg, input type_state exp);
    chk_t c;
    c.name = name; c.use_reg = use_reg; c.exp = exp;
    q.push_back(c);
    fork
      wait (q.size() == 0);
      #20;
    join_any
    disable fork;
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s: monitor did not consume the check within the time bound", name);
      q.delete();
    end
  endtask

  // Monitor: consumes each expectation shortly after it is posted.
  initial begin
    chk_t      c;
    type_state act;
    forever begin
      wait (q.size() != 0 || done);
      if (done) break;
      #1;
      c = q.pop_front();
      act = c.use_reg ? mux_reg : mux_comb;
      checks++;
      if (act !== c.exp) begin
        errors++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  type_state zero_s, pi_ref, po_ref, pi_alt, tmp;

  initial begin
    zero_s = '0;
    pi_ref = '{64'h8899aabbccddeeff, 64'h0011223344556677, 64'h08090a0b0c0d0e0f,
               64'h0001020304050607, ASCON128_IV};
    po_ref = '{64'hdcdddddfd9dddddd, 64'hdcd8f4c7e363e010, 64'hfd3d3d3d3d3d3d57,
               64'h0dc4f1a5aea83522, 64'he05e3fcced08e4f0};
    pi_s = pi_ref;
    po_s = po_ref;

    // Combinational select of the loaded state; asynchronous reset of the register.
    #2;
    resetb = 1'b0;
    expect_out("comb_sel0", 1'b0, pi_ref);
    expect_out("reg_async_reset", 1'b1, zero_s);
    @(posedge clk); @(posedge clk);
    expect_out("reg_reset_held", 1'b1, zero_s);
    @(negedge clk);
    resetb = 1'b1;
    expect_out("reg_release_no_edge", 1'b1, zero_s);
    @(posedge clk);
    expect_out("reg_first_load", 1'b1, pi_ref);

    // Feedback side selected without any clock edge.
    @(negedge clk);
    #2;
    sel = 1'b1;
    expect_out("comb_sel1", 1'b0, po_ref);
    po_s[2] = 64'h0;
    tmp = po_ref; tmp[2] = 64'h0;
    expect_out("comb_word2_zero", 1'b0, tmp);
    pi_alt = rand_state();
    pi_s = pi_alt;
    expect_out("comb_unselected_change", 1'b0, tmp);
    pi_s = pi_ref;
    po_s = po_ref;

    // Reset asserted between edges while the register runs.
    @(posedge clk);
    expect_out("reg_sel1", 1'b1, po_ref);
    @(negedge clk);
    #2;
    resetb = 1'b0;
    expect_out("reg_mid_reset", 1'b1, zero_s);
    @(posedge clk);
    expect_out("reg_mid_reset_edge", 1'b1, zero_s);
    @(negedge clk);
    resetb = 1'b1;
    expect_out("reg_mid_release", 1'b1, zero_s);
    @(posedge clk);
    expect_out("reg_reload", 1'b1, model(sel, pi_s, po_s));

    // Random traffic: simultaneous changes of selector and data.
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      pi_s = rand_state();
      po_s = rand_state();
      sel  = 1'($urandom_range(0, 1));
      expect_out("comb_rand", 1'b0, model(sel, pi_s, po_s));
      @(posedge clk);
      expect_out("reg_rand", 1'b1, model(sel, pi_s, po_s));
    end

    done = 1'b1;
    #5;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
